sdram_read_arbiter: RTL and testbench

// Shares the single SDRAM burst-read port between two requesters: the video

---
 rtl/sdram_read_arbiter_if.sv | 45 ++++
 rtl/sdram_read_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sdram_read_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_read_arbiter_if.sv
// rtl/sdram_read_arbiter_if.sv - request, routing and SDRAM burst-read signals of the read arbiter
// The slave modport is the arbiter's view; master is the view of the surrounding requesters and SDRAM controller.

interface sdram_read_arbiter_if;
  logic        vid_rd_request;
  logic [22:0] vid_rd_address;
  logic [8:0]  vid_rd_burst_length;
  logic        vid_rd_available;
  logic [31:0] vid_rd_data;

  logic        aux_rd_request;
  logic [22:0] aux_rd_address;
  logic [8:0]  aux_rd_burst_length;
  logic        aux_rd_available;
  logic [31:0] aux_rd_data;

  logic        sdram_rd_request;
  logic [22:0] sdram_rd_address;
  logic [8:0]  sdram_rd_burst_length;
  logic        sdram_rd_available;
  logic [31:0] sdram_rd_data;

  logic [1:0]  owner;
  logic        overrun;

  modport slave (
    input  vid_rd_request, vid_rd_address, vid_rd_burst_length,
    output vid_rd_available, vid_rd_data,
    input  aux_rd_request, aux_rd_address, aux_rd_burst_length,
    output aux_rd_available, aux_rd_data,
    output sdram_rd_request, sdram_rd_address, sdram_rd_burst_length,
    input  sdram_rd_available, sdram_rd_data,
    output owner, overrun
  );

  modport master (
    output vid_rd_request, vid_rd_address, vid_rd_burst_length,
    input  vid_rd_available, vid_rd_data,
    output aux_rd_request, aux_rd_address, aux_rd_burst_length,
    input  aux_rd_available, aux_rd_data,
    input  sdram_rd_request, sdram_rd_address, sdram_rd_burst_length,
    output sdram_rd_available, sdram_rd_data,
    input  owner, overrun
  );
endinterface

// File: rtl/sdram_read_arbiter.sv
// rtl/sdram_read_arbiter.sv - fixed-priority (video first) arbiter for the single SDRAM burst-read port
// Latches request pulses per port, issues one burst at a time and routes returned words to the burst owner.

module sdram_read_arbiter #(
  parameter int AUX_MAX_BURST = 80,
  parameter int TIMEOUT       = 1023
) (
  input logic                 clk,
  input logic                 reset,
  sdram_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_VID  = 2'b01;
  localparam logic [1:0] OWN_AUX  = 2'b10;

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0]      AUX_CLAMP  = 9'(AUX_MAX_BURST);

  state_e        state_q, state_d;
  logic          vid_pend_q, vid_pend_d;
  logic [22:0]   vid_addr_q, vid_addr_d;
  logic [8:0]    vid_len_q, vid_len_d;
  logic          aux_pend_q, aux_pend_d;
  logic [22:0]   aux_addr_q, aux_addr_d;
  logic [8:0]    aux_len_q, aux_len_d;
  logic [1:0]    owner_q, owner_d;
  logic [22:0]   iss_addr_q, iss_addr_d;
  logic [8:0]    iss_len_q, iss_len_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overrun_q, overrun_d;
  logic          vid_avail_q, vid_avail_d;
  logic [31:0]   vid_data_q, vid_data_d;
  logic          aux_avail_q, aux_avail_d;
  logic [31:0]   aux_data_q, aux_data_d;

  logic          drop_vid, drop_aux, timed_out;
  logic [8:0]    aux_len_clamped;

  always_comb begin
    state_d     = state_q;
    vid_pend_d  = vid_pend_q;
    vid_addr_d  = vid_addr_q;
    vid_len_d   = vid_len_q;
    aux_pend_d  = aux_pend_q;
    aux_addr_d  = aux_addr_q;
    aux_len_d   = aux_len_q;
    owner_d     = owner_q;
    iss_addr_d  = iss_addr_q;
    iss_len_d   = iss_len_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    vid_avail_d = 1'b0;
    vid_data_d  = vid_data_q;
    aux_avail_d = 1'b0;
    aux_data_d  = aux_data_q;
    timed_out   = 1'b0;

    // owner_q is non-zero exactly while a burst is in ISSUE or WAIT
    drop_vid = bus.vid_rd_request && (vid_pend_q || owner_q == OWN_VID);
    drop_aux = bus.aux_rd_request && (aux_pend_q || owner_q == OWN_AUX);
    aux_len_clamped = (bus.aux_rd_burst_length > AUX_CLAMP) ? AUX_CLAMP : bus.aux_rd_burst_length;

    // A zero-length request is accepted but never becomes pending
    if (bus.vid_rd_request && !drop_vid) begin
      vid_addr_d = bus.vid_rd_address;
      vid_len_d  = bus.vid_rd_burst_length;
      vid_pend_d = (bus.vid_rd_burst_length != 9'd0);
    end
    if (bus.aux_rd_request && !drop_aux) begin
      aux_addr_d = bus.aux_rd_address;
      aux_len_d  = aux_len_clamped;
      aux_pend_d = (aux_len_clamped != 9'd0);
    end

    case (state_q)
      S_IDLE: begin
        if (vid_pend_q) begin
          state_d    = S_ISSUE;
          owner_d    = OWN_VID;
          iss_addr_d = vid_addr_q;
          iss_len_d  = vid_len_q;
        end else if (aux_pend_q) begin
          state_d    = S_ISSUE;
          owner_d    = OWN_AUX;
          iss_addr_d = aux_addr_q;
          iss_len_d  = aux_len_q;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = 9'd0;
        timer_d = '0;
        if (owner_q == OWN_VID) vid_pend_d = 1'b0;
        if (owner_q == OWN_AUX) aux_pend_d = 1'b0;
      end
      S_WAIT: begin
        if (bus.sdram_rd_available) begin
          timer_d = '0;
          if (cnt_q == iss_len_q - 9'd1) begin
            state_d = S_IDLE;
            owner_d = OWN_NONE;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d   = S_IDLE;
          owner_d   = OWN_NONE;
          timed_out = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    // Words are only accepted while a burst is waiting for data
    if (state_q == S_WAIT && bus.sdram_rd_available) begin
      if (owner_q == OWN_VID) begin
        vid_avail_d = 1'b1;
        vid_data_d  = bus.sdram_rd_data;
      end
      if (owner_q == OWN_AUX) begin
        aux_avail_d = 1'b1;
        aux_data_d  = bus.sdram_rd_data;
      end
    end

    overrun_d = drop_vid || drop_aux || timed_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vid_pend_q  <= 1'b0;
      vid_addr_q  <= '0;
      vid_len_q   <= '0;
      aux_pend_q  <= 1'b0;
      aux_addr_q  <= '0;
      aux_len_q   <= '0;
      owner_q     <= OWN_NONE;
      iss_addr_q  <= '0;
      iss_len_q   <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      overrun_q   <= 1'b0;
      vid_avail_q <= 1'b0;
      vid_data_q  <= '0;
      aux_avail_q <= 1'b0;
      aux_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      vid_pend_q  <= vid_pend_d;
      vid_addr_q  <= vid_addr_d;
      vid_len_q   <= vid_len_d;
      aux_pend_q  <= aux_pend_d;
      aux_addr_q  <= aux_addr_d;
      aux_len_q   <= aux_len_d;
      owner_q     <= owner_d;
      iss_addr_q  <= iss_addr_d;
      iss_len_q   <= iss_len_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      overrun_q   <= overrun_d;
      vid_avail_q <= vid_avail_d;
      vid_data_q  <= vid_data_d;
      aux_avail_q <= aux_avail_d;
      aux_data_q  <= aux_data_d;
    end
  end

  assign bus.sdram_rd_request      = (state_q == S_ISSUE);
  assign bus.sdram_rd_address      = iss_addr_q;
  assign bus.sdram_rd_burst_length = iss_len_q;
  assign bus.owner                 = owner_q;
  assign bus.overrun               = overrun_q;
  assign bus.vid_rd_available      = vid_avail_q;
  assign bus.vid_rd_data           = vid_data_q;
  assign bus.aux_rd_available      = aux_avail_q;
  assign bus.aux_rd_data           = aux_data_q;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb/tb_sdram_read_arbiter.sv - self-checking bench for sdram_read_arbiter
// Table of single bursts plus hand-written priority, drop, timeout and reset sequences.

module tb_sdram_read_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_read_arbiter_if bus();

  sdram_read_arbiter #(.AUX_MAX_BURST(80), .TIMEOUT(1023)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_aux;
    logic [22:0] addr;
    logic [8:0]  len;
    logic [8:0]  exp_len;
  } rec_t;

  rec_t        tbl[10];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_vid[$];
  logic [31:0] exp_aux[$];
  int          vid_words = 0;
  int          aux_words = 0;
  int          req_count = 0;
  int          ovr_count = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Routed words are compared against the words the bench handed to the SDRAM side
  always @(negedge clk) begin
    if (bus.vid_rd_available === 1'b1) begin
      vid_words++;
      if (exp_vid.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL vid_unexpected_word: got 0x%0h expected no word", bus.vid_rd_data);
      end else begin
        check("vid_word", bus.vid_rd_data, exp_vid.pop_front());
      end
    end
    if (bus.aux_rd_available === 1'b1) begin
      aux_words++;
      if (exp_aux.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL aux_unexpected_word: got 0x%0h expected no word", bus.aux_rd_data);
      end else begin
        check("aux_word", bus.aux_rd_data, exp_aux.pop_front());
      end
    end
    if (bus.sdram_rd_request === 1'b1) req_count++;
    if (bus.overrun === 1'b1) ovr_count++;
  end

  task automatic pulse(input logic is_aux, input logic [22:0] a, input logic [8:0] l);
    if (is_aux) begin
      bus.aux_rd_request = 1'b1; bus.aux_rd_address = a; bus.aux_rd_burst_length = l;
    end else begin
      bus.vid_rd_request = 1'b1; bus.vid_rd_address = a; bus.vid_rd_burst_length = l;
    end
    tick();
    bus.vid_rd_request = 1'b0;
    bus.aux_rd_request = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (bus.sdram_rd_request !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic drive_word(input logic is_aux, input logic expected);
    logic [31:0] d;
    d = $urandom;
    bus.sdram_rd_available = 1'b1;
    bus.sdram_rd_data = d;
    if (expected) begin
      if (is_aux) exp_aux.push_back(d);
      else exp_vid.push_back(d);
    end
    tick();
    bus.sdram_rd_available = 1'b0;
  endtask

  // Called in the ISSUE cycle; returns just after the edge that takes the last word
  task automatic feed(input logic is_aux, input int n);
    tick();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      drive_word(is_aux, 1'b1);
    end
  endtask

  task automatic run_rec(input rec_t r);
    int v0, a0, r0, o0, lat;
    v0 = vid_words; a0 = aux_words; r0 = req_count; o0 = ovr_count;
    pulse(r.is_aux, r.addr, r.len);
    if (r.exp_len == 9'd0) begin
      repeat (6) tick();
      check("zero_len_no_request", req_count - r0, 0);
      check("zero_len_no_overrun", ovr_count - o0, 0);
    end else begin
      wait_req(lat);
      check("issue_latency", lat + 1, 2);
      check("burst_address", bus.sdram_rd_address, r.addr);
      check("burst_length", bus.sdram_rd_burst_length, r.exp_len);
      check("owner_issue", bus.owner, r.is_aux ? 2 : 1);
      feed(r.is_aux, r.exp_len);
      check("owner_after_burst", bus.owner, 0);
      tick();
      check("vid_word_count", vid_words - v0, r.is_aux ? 0 : r.exp_len);
      check("aux_word_count", aux_words - a0, r.is_aux ? r.exp_len : 0);
      check("request_count", req_count - r0, 1);
      check("no_overrun", ovr_count - o0, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, r0, o0, v0;

    tbl[0] = '{1'b0, 23'h000100, 9'd80,  9'd80};
    tbl[1] = '{1'b1, 23'h012340, 9'd200, 9'd80};
    tbl[2] = '{1'b1, 23'h7FFFFF, 9'd81,  9'd80};
    tbl[3] = '{1'b1, 23'h000200, 9'd80,  9'd80};
    tbl[4] = '{1'b0, 23'h400000, 9'd300, 9'd300};
    tbl[5] = '{1'b0, 23'h000001, 9'd1,   9'd1};
    tbl[6] = '{1'b1, 23'h0000AA, 9'd1,   9'd1};
    tbl[7] = '{1'b0, 23'h000300, 9'd0,   9'd0};
    tbl[8] = '{1'b1, 23'h000400, 9'd0,   9'd0};
    tbl[9] = '{1'b0, 23'h1ABCDE, 9'd511, 9'd511};

    reset = 1'b1;
    bus.vid_rd_request = 1'b0; bus.vid_rd_address = '0; bus.vid_rd_burst_length = '0;
    bus.aux_rd_request = 1'b0; bus.aux_rd_address = '0; bus.aux_rd_burst_length = '0;
    bus.sdram_rd_available = 1'b0; bus.sdram_rd_data = '0;
    repeat (3) tick();
    check("reset_sdram_request", bus.sdram_rd_request, 0);
    check("reset_sdram_address", bus.sdram_rd_address, 0);
    check("reset_sdram_length", bus.sdram_rd_burst_length, 0);
    check("reset_owner", bus.owner, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_vid_available", bus.vid_rd_available, 0);
    check("reset_aux_available", bus.aux_rd_available, 0);
    check("reset_vid_data", bus.vid_rd_data, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_rec(tbl[i]);

    // Simultaneous pulses: video first, aux issued the cycle after video's last routed word
    r0 = req_count;
    bus.vid_rd_request = 1'b1; bus.vid_rd_address = 23'h000500; bus.vid_rd_burst_length = 9'd4;
    bus.aux_rd_request = 1'b1; bus.aux_rd_address = 23'h000600; bus.aux_rd_burst_length = 9'd3;
    tick();
    bus.vid_rd_request = 1'b0; bus.aux_rd_request = 1'b0;
    wait_req(lat);
    check("both_issue_latency", lat + 1, 2);
    check("both_first_owner", bus.owner, 1);
    check("both_first_address", bus.sdram_rd_address, 23'h000500);
    feed(1'b0, 4);
    check("both_gap_no_request", bus.sdram_rd_request, 0);
    check("both_last_vid_word", bus.vid_rd_available, 1);
    tick();
    check("both_aux_request", bus.sdram_rd_request, 1);
    check("both_aux_owner", bus.owner, 2);
    check("both_aux_address", bus.sdram_rd_address, 23'h000600);
    check("both_aux_length", bus.sdram_rd_burst_length, 3);
    feed(1'b1, 3);
    tick();
    check("both_aux_drained", exp_aux.size(), 0);
    check("both_request_count", req_count - r0, 2);

    // Repeat pulses on a busy or pending slot are dropped with an overrun pulse
    r0 = req_count; o0 = ovr_count;
    pulse(1'b0, 23'h000700, 9'd8);
    wait_req(lat);
    tick();
    for (int i = 0; i < 3; i++) drive_word(1'b0, 1'b1);
    pulse(1'b0, 23'h000777, 9'd5);
    check("vid_drop_overrun", bus.overrun, 1);
    pulse(1'b1, 23'h000800, 9'd2);
    check("overrun_single_cycle", bus.overrun, 0);
    pulse(1'b1, 23'h000900, 9'd2);
    check("aux_drop_overrun", bus.overrun, 1);
    for (int i = 0; i < 5; i++) drive_word(1'b0, 1'b1);
    tick();
    check("drop_aux_request", bus.sdram_rd_request, 1);
    check("drop_aux_address", bus.sdram_rd_address, 23'h000800);
    feed(1'b1, 2);
    repeat (5) tick();
    check("drop_request_count", req_count - r0, 2);
    check("drop_overrun_count", ovr_count - o0, 2);
    check("drop_vid_drained", exp_vid.size(), 0);

    // Silent SDRAM: burst abandoned after exactly TIMEOUT waiting cycles, then pending aux issues
    v0 = vid_words;
    pulse(1'b0, 23'h000A00, 9'd4);
    wait_req(lat);
    pulse(1'b1, 23'h000B00, 9'd5);
    n = 1;
    while (bus.overrun !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 1024);
    check("timeout_owner", bus.owner, 0);
    tick();
    check("timeout_aux_request", bus.sdram_rd_request, 1);
    check("timeout_aux_address", bus.sdram_rd_address, 23'h000B00);
    check("timeout_aux_owner", bus.owner, 2);
    feed(1'b1, 5);
    tick();
    check("timeout_aux_drained", exp_aux.size(), 0);
    check("timeout_no_vid_words", vid_words - v0, 0);

    // Reset after 10 of 80 words: outputs cleared, later words discarded
    pulse(1'b0, 23'h000C00, 9'd80);
    wait_req(lat);
    feed(1'b0, 10);
    reset = 1'b1;
    drive_word(1'b0, 1'b0);
    check("rst_vid_available", bus.vid_rd_available, 0);
    check("rst_vid_data", bus.vid_rd_data, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_sdram_request", bus.sdram_rd_request, 0);
    check("rst_sdram_length", bus.sdram_rd_burst_length, 0);
    check("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    r0 = req_count;
    for (int i = 0; i < 5; i++) drive_word(1'b0, 1'b0);
    tick();
    check("rst_owner_after", bus.owner, 0);
    check("rst_no_request", req_count - r0, 0);
    check("rst_vid_drained", exp_vid.size(), 0);
    run_rec(tbl[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
